// File: rtl/bank_arbiter_if.sv
// Requester and memory-bank signal bundle for bank_arbiter.
// master = arbiter side, slave = requesters plus bank.
interface bank_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_write;
    logic [8*NUM_REQ-1:0] req_addr;
    logic [8*NUM_REQ-1:0] req_wdata;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ-1:0]   resp_valid;
    logic [7:0]           resp_data;
    logic                 resp_err;
    logic                 bank_read;
    logic                 bank_write;
    logic [7:0]           bank_addr;
    logic [7:0]           bank_data_in;
    logic [7:0]           bank_data_out;
    logic                 bank_finish;

    modport master (
        input  req_valid,
        input  req_write,
        input  req_addr,
        input  req_wdata,
        output req_ready,
        output resp_valid,
        output resp_data,
        output resp_err,
        output bank_read,
        output bank_write,
        output bank_addr,
        output bank_data_in,
        input  bank_data_out,
        input  bank_finish
    );

    modport slave (
        output req_valid,
        output req_write,
        output req_addr,
        output req_wdata,
        input  req_ready,
        input  resp_valid,
        input  resp_data,
        input  resp_err,
        input  bank_read,
        input  bank_write,
        input  bank_addr,
        input  bank_data_in,
        output bank_data_out,
        output bank_finish
    );
endinterface

// File: rtl/bank_arbiter.sv
// Round-robin arbiter granting NUM_REQ requesters access to one memory bank.
// One transaction in flight; all outputs registered; WAIT guarded by a timeout.
module bank_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 8
) (
    input logic           clock,
    input logic           reset,
    bank_arbiter_if.master bus
);
    localparam int PW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
    localparam logic [3:0] CNT_LAST = 4'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [PW-1:0]      ptr_q, ptr_d;
    logic [PW-1:0]      grant_q, grant_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               write_q, write_d;
    logic [7:0]         addr_q, addr_d;
    logic [7:0]         wdata_q, wdata_d;
    logic [NUM_REQ-1:0] ready_q, ready_d;
    logic [NUM_REQ-1:0] rvalid_q, rvalid_d;
    logic [7:0]         rdata_q, rdata_d;
    logic               rerr_q, rerr_d;
    logic               rd_q, rd_d;
    logic               wr_q, wr_d;

    logic               pick_hit;
    logic [PW-1:0]      pick_idx;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] v);
        if (int'(v) == NUM_REQ - 1) return '0;
        return v + 1'b1;
    endfunction

    // First pending requester at or above ptr, wrapping around.
    always_comb begin : pick
        int idx;
        pick_hit = 1'b0;
        pick_idx = '0;
        idx = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!pick_hit && bus.req_valid[PW'(idx)]) begin
                pick_hit = 1'b1;
                pick_idx = PW'(idx);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        cnt_d    = cnt_q;
        write_d  = write_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        ready_d  = '0;
        rvalid_d = '0;
        rdata_d  = 8'h00;
        rerr_d   = 1'b0;
        rd_d     = 1'b0;
        wr_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_hit) begin
                    grant_d           = pick_idx;
                    write_d           = bus.req_write[pick_idx];
                    addr_d            = bus.req_addr[8*pick_idx +: 8];
                    wdata_d           = bus.req_wdata[8*pick_idx +: 8];
                    ready_d[pick_idx] = 1'b1;
                    rd_d              = !bus.req_write[pick_idx];
                    wr_d              = bus.req_write[pick_idx];
                    state_d           = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.bank_finish) begin
                    rvalid_d[grant_q] = 1'b1;
                    rdata_d = write_q ? 8'h00 : bus.bank_data_out;
                    ptr_d   = wrap_inc(grant_q);
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    rvalid_d[grant_q] = 1'b1;
                    rerr_d  = 1'b1;
                    ptr_d   = wrap_inc(grant_q);
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            grant_q  <= '0;
            cnt_q    <= '0;
            write_q  <= 1'b0;
            addr_q   <= 8'h00;
            wdata_q  <= 8'h00;
            ready_q  <= '0;
            rvalid_q <= '0;
            rdata_q  <= 8'h00;
            rerr_q   <= 1'b0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            cnt_q    <= cnt_d;
            write_q  <= write_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            ready_q  <= ready_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            rerr_q   <= rerr_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
        end
    end

    assign bus.req_ready    = ready_q;
    assign bus.resp_valid   = rvalid_q;
    assign bus.resp_data    = rdata_q;
    assign bus.resp_err     = rerr_q;
    assign bus.bank_read    = rd_q;
    assign bus.bank_write   = wr_q;
    assign bus.bank_addr    = addr_q;
    assign bus.bank_data_in = wdata_q;

    a_ready_onehot: assert property (
        @(posedge clock) disable iff (!reset) $onehot0(ready_q));
    a_resp_onehot: assert property (
        @(posedge clock) disable iff (!reset) $onehot0(rvalid_q));
    a_strobe_excl: assert property (
        @(posedge clock) disable iff (!reset) !(rd_q && wr_q));
endmodule

// File: tb/tb_bank_arbiter.sv
// Scoreboard bench for bank_arbiter: expected grants and responses are queued
// as requests are driven and retired as the arbiter produces them.
module tb_bank_arbiter;
    localparam int NUM_REQ = 4;
    localparam int TIMEOUT = 8;

    typedef struct {
        int         idx;
        bit         write;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
        bit         err;
        int         lat;
        int         gap;
        int         start;
    } txn_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   last_grant = 0;
    bit   bank_en = 1'b1;
    bit   one_shot [NUM_REQ];
    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];
    txn_t exp_grant [$];
    txn_t exp_resp [$];

    always #5 clk = ~clk;

    bank_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    bank_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
        .clock(clk),
        .reset(rst_n),
        .bus(bus)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Bank: finish one cycle after a strobe, registered read data.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.bank_finish   <= 1'b0;
            bus.bank_data_out <= 8'h00;
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h3C;
        end else begin
            bus.bank_finish <= bank_en & (bus.bank_read | bus.bank_write);
            if (bus.bank_read) bus.bank_data_out <= mem[bus.bank_addr];
            if (bus.bank_write) mem[bus.bank_addr] <= bus.bank_data_in;
        end
    end

    task automatic check(string tag, logic [31:0] got, logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    always @(negedge clk) begin : mon
        txn_t t;
        if (rst_n) begin
            if ((bus.bank_read | bus.bank_write) && bus.req_ready == '0)
                check("strobe_len", 1, 0);
            if (bus.req_ready != '0) begin
                if (exp_grant.size() == 0) begin
                    check("extra_grant", 32'(bus.req_ready), 0);
                end else begin
                    t = exp_grant.pop_front();
                    check("grant", 32'(bus.req_ready), 32'(1 << t.idx));
                    check("strobe", {30'b0, bus.bank_read, bus.bank_write},
                          t.write ? 32'd1 : 32'd2);
                    check("bank_addr", 32'(bus.bank_addr), 32'(t.addr));
                    if (t.write)
                        check("bank_wdata", 32'(bus.bank_data_in), 32'(t.wdata));
                    if (t.gap != 0) check("gap", cyc - last_grant, t.gap);
                    last_grant = cyc;
                    t.start = cyc;
                    exp_resp.push_back(t);
                end
            end
            if (bus.resp_valid != '0) begin
                if (exp_resp.size() == 0) begin
                    check("extra_resp", 32'(bus.resp_valid), 0);
                end else begin
                    t = exp_resp.pop_front();
                    check("resp_idx", 32'(bus.resp_valid), 32'(1 << t.idx));
                    check("resp_data", 32'(bus.resp_data), 32'(t.rdata));
                    check("resp_err", 32'(bus.resp_err), 32'(t.err));
                    check("resp_lat", cyc - t.start, t.lat);
                end
            end
        end
    end

    task automatic ref_init();
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'h3C;
    endtask

    task automatic expect_txn(int i, bit wr, logic [7:0] a, logic [7:0] d,
                              int gap, bit tmo);
        txn_t t;
        t.idx = i;
        t.write = wr;
        t.addr = a;
        t.wdata = d;
        t.err = tmo;
        t.lat = tmo ? 1 + TIMEOUT : 2;
        t.gap = gap;
        t.start = 0;
        t.rdata = (wr || tmo) ? 8'h00 : ref_mem[a];
        if (wr) ref_mem[a] = d;
        exp_grant.push_back(t);
    endtask

    task automatic drive(int i, bit wr, logic [7:0] a, logic [7:0] d, bit shot);
        bus.req_write[i] = wr;
        bus.req_addr[8*i +: 8] = a;
        bus.req_wdata[8*i +: 8] = d;
        bus.req_valid[i] = 1'b1;
        one_shot[i] = shot;
    endtask

    task automatic step(int n);
        repeat (n) begin
            @(negedge clk);
            for (int i = 0; i < NUM_REQ; i++)
                if (one_shot[i] && bus.req_ready[i]) begin
                    bus.req_valid[i] = 1'b0;
                    one_shot[i] = 1'b0;
                end
        end
    endtask

    task automatic wait_granted(int maxc);
        int n;
        n = 0;
        while (exp_grant.size() != 0 && n < maxc) begin
            step(1);
            n++;
        end
        if (n >= maxc) begin
            check("grant_timeout", 1, 0);
            exp_grant.delete();
        end
    endtask

    task automatic drain(int maxc);
        int n;
        n = 0;
        while ((exp_grant.size() != 0 || exp_resp.size() != 0) && n < maxc) begin
            step(1);
            n++;
        end
        if (n >= maxc) begin
            check("drain_timeout", 1, 0);
            exp_grant.delete();
            exp_resp.delete();
            bus.req_valid = '0;
        end
        step(2);
    endtask

    task automatic check_quiet(string pfx);
        check({pfx, "_ready"}, 32'(bus.req_ready), 0);
        check({pfx, "_rvalid"}, 32'(bus.resp_valid), 0);
        check({pfx, "_rdata"}, 32'(bus.resp_data), 0);
        check({pfx, "_rerr"}, 32'(bus.resp_err), 0);
        check({pfx, "_rd"}, 32'(bus.bank_read), 0);
        check({pfx, "_wr"}, 32'(bus.bank_write), 0);
        check({pfx, "_addr"}, 32'(bus.bank_addr), 0);
        check({pfx, "_wdata"}, 32'(bus.bank_data_in), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.req_valid = '0;
        bus.req_write = '0;
        bus.req_addr = '0;
        bus.req_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) one_shot[i] = 1'b0;
        ref_init();
        rst_n = 1'b0;
        step(2);
        check_quiet("rst");
        #2 rst_n = 1'b1;
        step(2);

        // Write then read back through requester 2.
        expect_txn(2, 1'b1, 8'h10, 8'h5A, 0, 1'b0);
        drive(2, 1'b1, 8'h10, 8'h5A, 1'b1);
        drain(100);
        check("addr_hold", 32'(bus.bank_addr), 32'h10);
        check("wdata_hold", 32'(bus.bank_data_in), 32'h5A);
        expect_txn(2, 1'b0, 8'h10, 8'h00, 0, 1'b0);
        drive(2, 1'b0, 8'h10, 8'h00, 1'b1);
        drain(100);

        // All four held high from reset: 0,1,2,3,0 every 3 cycles.
        rst_n = 1'b0;
        ref_init();
        drive(0, 1'b1, 8'h20, 8'h11, 1'b0);
        drive(1, 1'b0, 8'h20, 8'h00, 1'b0);
        drive(2, 1'b1, 8'h21, 8'h22, 1'b0);
        drive(3, 1'b0, 8'h21, 8'h00, 1'b0);
        expect_txn(0, 1'b1, 8'h20, 8'h11, 0, 1'b0);
        expect_txn(1, 1'b0, 8'h20, 8'h00, 3, 1'b0);
        expect_txn(2, 1'b1, 8'h21, 8'h22, 3, 1'b0);
        expect_txn(3, 1'b0, 8'h21, 8'h00, 3, 1'b0);
        expect_txn(0, 1'b1, 8'h20, 8'h11, 3, 1'b0);
        step(1);
        #2 rst_n = 1'b1;
        wait_granted(60);
        bus.req_valid = '0;
        drain(100);

        // Move ptr to 2, then 1 and 3 together: 3 wins, then 1.
        expect_txn(1, 1'b0, 8'h40, 8'h00, 0, 1'b0);
        drive(1, 1'b0, 8'h40, 8'h00, 1'b1);
        drain(100);
        expect_txn(3, 1'b0, 8'h20, 8'h00, 0, 1'b0);
        expect_txn(1, 1'b0, 8'h21, 8'h00, 3, 1'b0);
        drive(1, 1'b0, 8'h21, 8'h00, 1'b1);
        drive(3, 1'b0, 8'h20, 8'h00, 1'b1);
        drain(100);

        // Bank never finishes: timeout error, ptr still advances.
        bank_en = 1'b0;
        expect_txn(0, 1'b0, 8'h30, 8'h00, 0, 1'b1);
        drive(0, 1'b0, 8'h30, 8'h00, 1'b1);
        drain(100);
        bank_en = 1'b1;
        expect_txn(1, 1'b1, 8'h31, 8'h77, 0, 1'b0);
        expect_txn(0, 1'b0, 8'h31, 8'h00, 3, 1'b0);
        drive(0, 1'b0, 8'h31, 8'h00, 1'b1);
        drive(1, 1'b1, 8'h31, 8'h77, 1'b1);
        drain(100);

        // Reset during WAIT aborts; ptr restarts at 0.
        bank_en = 1'b0;
        expect_txn(2, 1'b0, 8'h31, 8'h00, 0, 1'b1);
        drive(2, 1'b0, 8'h31, 8'h00, 1'b1);
        wait_granted(20);
        step(3);
        drive(0, 1'b1, 8'h50, 8'h99, 1'b1);
        drive(2, 1'b0, 8'h50, 8'h00, 1'b1);
        #2 rst_n = 1'b0;
        exp_resp.delete();
        ref_init();
        #1 check_quiet("abort");
        bank_en = 1'b1;
        expect_txn(0, 1'b1, 8'h50, 8'h99, 0, 1'b0);
        expect_txn(2, 1'b0, 8'h50, 8'h00, 3, 1'b0);
        step(1);
        #3 rst_n = 1'b1;
        drain(100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
